memory_cycle: RTL and testbench



---
 rtl/memory_cycle_pkg.sv | 38 +++
 rtl/memory_cycle_if.sv | 32 +++
 rtl/memory_cycle_data_mem.sv | 27 ++
 rtl/memory_cycle.sv | 113 +++++++++++
 tb/tb_memory_cycle.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared types for the memory-access pipeline stage: FSM states, the latched
// request and the MEM/WB bundle handed to write-back.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] sdata;
        logic [REG_W-1:0]  rd;
        logic              mem_r;
        logic              mem_w;
        logic              wb;
        logic              regw;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] wb_data;
        logic [REG_W-1:0]  rd;
        logic              regw;
        logic              misalign;
    } memwb_t;

    function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
        return |(addr[1:0] & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Execute -> memory stage request bus plus the registered MEM/WB outputs.
interface memory_cycle_if;
    import pipe_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] Alu_Res;
    logic [DATA_W-1:0] Store_Data;
    logic [REG_W-1:0]  Rd2;
    logic              mem_R;
    logic              mem_W;
    logic              WB;
    logic              RegW;
    logic              stall;
    logic              out_valid;
    logic [DATA_W-1:0] Mem_Data;
    logic [DATA_W-1:0] Alu_Res_out;
    logic [DATA_W-1:0] Wb_Data;
    logic [REG_W-1:0]  Rd3;
    logic              RegW_out;
    logic              misalign;

    modport master (
        output in_valid, Alu_Res, Store_Data, Rd2, mem_R, mem_W, WB, RegW,
        input  stall, out_valid, Mem_Data, Alu_Res_out, Wb_Data, Rd3, RegW_out, misalign
    );

    modport slave (
        input  in_valid, Alu_Res, Store_Data, Rd2, mem_R, mem_W, WB, RegW,
        output stall, out_valid, Mem_Data, Alu_Res_out, Wb_Data, Rd3, RegW_out, misalign
    );

endinterface

// File: rtl/memory_cycle_data_mem.sv
// Single-port synchronous data RAM; the registered read returns the old word
// when a write hits the same index on the same edge.
module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[index] <= wdata;
        end
        r_rdata <= r_mem[index];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/memory_cycle.sv
// Memory-access stage: single-cycle pass-through for ALU ops and misaligned
// accesses, fixed-latency load/store through data_mem with upstream stall.
//
//   state | meaning
//   IDLE  | accepting a new instruction from execute
//   BUSY  | access in flight, counting down wait cycles, inputs ignored
module memory_cycle
    import pipe_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input logic           clk,
    input logic           rst,
    memory_cycle_if.slave bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    req_t              r_req, w_req_nxt, w_in_req;
    memwb_t            r_memwb, w_memwb_nxt;
    logic              w_we;
    logic [ADDR_W-1:0] w_index;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_load_data;

    assign w_in_req = '{addr: bus.Alu_Res, sdata: bus.Store_Data, rd: bus.Rd2,
                        mem_r: bus.mem_R, mem_w: bus.mem_W, wb: bus.WB, regw: bus.RegW};

    // The RAM reads the incoming address at acceptance and the latched one
    // while busy, so rdata already holds the word when the count expires.
    assign w_index = (r_state == IDLE) ? bus.Alu_Res[ADDR_W+1:2] : r_req.addr[ADDR_W+1:2];

    data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data_mem (
        .clk   (clk),
        .we    (w_we & ~rst),
        .index (w_index),
        .wdata (r_req.sdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_memwb <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req   <= w_req_nxt;
            r_memwb <= w_memwb_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_req_nxt            = r_req;
        w_memwb_nxt          = r_memwb;
        w_memwb_nxt.valid    = 1'b0;
        w_memwb_nxt.misalign = 1'b0;
        w_we                 = 1'b0;
        w_load_data          = '0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!(bus.mem_R || bus.mem_W)) begin
                        w_memwb_nxt = '{valid: 1'b1, mem_data: '0, alu_res: bus.Alu_Res,
                                        wb_data: bus.WB ? '0 : bus.Alu_Res, rd: bus.Rd2,
                                        regw: bus.RegW, misalign: 1'b0};
                    end else if (is_misaligned(bus.Alu_Res)) begin
                        w_memwb_nxt = '{valid: 1'b1, mem_data: '0, alu_res: bus.Alu_Res,
                                        wb_data: bus.WB ? '0 : bus.Alu_Res, rd: bus.Rd2,
                                        regw: 1'b0, misalign: 1'b1};
                    end else begin
                        w_req_nxt   = w_in_req;
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_we = r_req.mem_w;
                    // A request with both bits set behaves as a store.
                    w_load_data = (r_req.mem_r && !r_req.mem_w) ? w_rdata : '0;
                    w_memwb_nxt = '{valid: 1'b1, mem_data: w_load_data, alu_res: r_req.addr,
                                    wb_data: r_req.wb ? w_load_data : r_req.addr, rd: r_req.rd,
                                    regw: r_req.regw, misalign: 1'b0};
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.stall       = (r_state == BUSY);
    assign bus.out_valid   = r_memwb.valid;
    assign bus.Mem_Data    = r_memwb.mem_data;
    assign bus.Alu_Res_out = r_memwb.alu_res;
    assign bus.Wb_Data     = r_memwb.wb_data;
    assign bus.Rd3         = r_memwb.rd;
    assign bus.RegW_out    = r_memwb.regw;
    assign bus.misalign    = r_memwb.misalign;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: a transaction-level model predicts each
// completion edge and MEM/WB bundle; a negedge process compares every cycle.
module tb_memory_cycle;

    localparam int MEM_LAT = 2;

    typedef struct {
        int          due;
        int          kind;   // 0 alu, 1 misaligned, 2 load, 3 store
        logic [7:0]  idx;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        wb;
        logic        regw;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_cnt = 0;
    int   bs = 0;
    int   be = 0;
    bit   live = 0;
    exp_t q[$];
    logic [31:0] mem_m [256];

    // Current expected MEM/WB contents (held between completions).
    logic [31:0] c_mem, c_alu, c_wbd;
    logic [4:0]  c_rd;
    logic        c_regw;
    bit          due, exp_mis;
    exp_t        e;

    memory_cycle_if bus ();

    memory_cycle #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(MEM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.stall) stall_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            due = (q.size() > 0) && (q[0].due == cyc);
            exp_mis = 0;
            if (due) begin
                e = q.pop_front();
                c_mem = (e.kind == 2) ? mem_m[e.idx] : 32'h0;
                if (e.kind == 3) mem_m[e.idx] = e.sd;
                c_alu  = e.alu;
                c_wbd  = e.wb ? c_mem : e.alu;
                c_rd   = e.rd;
                c_regw = (e.kind == 1) ? 1'b0 : e.regw;
                exp_mis = (e.kind == 1);
            end
            check("out_valid", {31'b0, bus.out_valid}, {31'b0, due});
            check("misalign", {31'b0, bus.misalign}, {31'b0, exp_mis});
            check("stall", {31'b0, bus.stall}, {31'b0, (cyc >= bs && cyc < be)});
            check("Mem_Data", bus.Mem_Data, c_mem);
            check("Alu_Res_out", bus.Alu_Res_out, c_alu);
            check("Wb_Data", bus.Wb_Data, c_wbd);
            check("Rd3", {27'b0, bus.Rd3}, {27'b0, c_rd});
            check("RegW_out", {31'b0, bus.RegW_out}, {31'b0, c_regw});
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.mem_W = 1'b1; bus.mem_R = 1'b0;
        bus.Alu_Res = 32'h0000_0008; bus.Store_Data = 32'hFFFF_0000;
        bus.Rd2 = 5'd3; bus.WB = 1'b0; bus.RegW = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            q.delete();
            c_mem = '0; c_alu = '0; c_wbd = '0; c_rd = '0; c_regw = 1'b0;
            bs = 0; be = 0;
            live = 1;
        end
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.mem_W = 1'b0;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic wb, input logic regw,
                         input bit junk, input bit wait_done);
        exp_t x;
        int lat;
        bus.in_valid = 1'b1; bus.Alu_Res = addr; bus.Store_Data = sd; bus.Rd2 = rd;
        bus.mem_R = mr; bus.mem_W = mw; bus.WB = wb; bus.RegW = regw;
        if (!(mr || mw))           x.kind = 0;
        else if (addr[1:0] != 0)   x.kind = 1;
        else if (mw)               x.kind = 3;
        else                       x.kind = 2;
        lat = (x.kind >= 2) ? MEM_LAT : 0;
        x.idx = addr[9:2]; x.alu = addr; x.sd = sd; x.rd = rd; x.wb = wb; x.regw = regw;
        x.due = cyc + 1 + lat;
        q.push_back(x);
        if (x.kind >= 2) begin
            bs = cyc + 1;
            be = cyc + 1 + MEM_LAT;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (!wait_done) return;
        repeat (lat) begin
            if (junk) begin
                bus.in_valid = 1'b1; bus.Alu_Res = 32'h0000_0008; bus.mem_W = 1'b1;
                bus.mem_R = 1'b0; bus.Store_Data = 32'hBAD0_BAD0; bus.Rd2 = 5'd31;
                bus.WB = 1'b1; bus.RegW = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.Alu_Res = '0; bus.Store_Data = '0; bus.Rd2 = '0;
        bus.mem_R = 1'b0; bus.mem_W = 1'b0; bus.WB = 1'b0; bus.RegW = 1'b0;
        c_mem = '0; c_alu = '0; c_wbd = '0; c_rd = '0; c_regw = 1'b0;
        @(posedge clk); #1;

        // reset with a store pending on the inputs
        do_reset(2);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_Wb_Data", bus.Wb_Data, 32'h0);
        idle(1);

        // ALU pass-through
        stall_cnt = 0;
        issue(32'h0111_1111, 32'h0, 5'd5, 0, 0, 0, 1, 0, 1);
        check("alu_Wb_Data", bus.Wb_Data, 32'h0111_1111);
        check("alu_Rd3", {27'b0, bus.Rd3}, 32'd5);
        check("alu_stall_cycles", stall_cnt, 32'd0);
        idle(2);

        // store then load
        stall_cnt = 0;
        issue(32'h0000_0008, 32'hDEAD_BEEF, 5'd0, 0, 1, 0, 0, 0, 1);
        check("st_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("st_stall_cycles", stall_cnt, 32'd2);
        issue(32'h0000_0008, 32'h0, 5'd7, 1, 0, 1, 1, 0, 1);
        check("ld_Mem_Data", bus.Mem_Data, 32'hDEAD_BEEF);
        check("ld_Wb_Data", bus.Wb_Data, 32'hDEAD_BEEF);
        idle(1);

        // misaligned load
        stall_cnt = 0;
        issue(32'h0000_0006, 32'h0, 5'd9, 1, 0, 1, 1, 0, 1);
        check("mis_flag", {31'b0, bus.misalign}, 32'd1);
        check("mis_RegW_out", {31'b0, bus.RegW_out}, 32'd0);
        check("mis_Mem_Data", bus.Mem_Data, 32'h0);
        check("mis_stall_cycles", stall_cnt, 32'd0);

        // wrapped store with inputs changing while busy, then load back
        issue(32'h0000_0400, 32'h1234_5678, 5'd1, 0, 1, 0, 0, 1, 1);
        issue(32'h0000_0000, 32'h0, 5'd2, 1, 0, 1, 1, 0, 1);
        check("wrap_Wb_Data", bus.Wb_Data, 32'h1234_5678);
        issue(32'h0000_0008, 32'h0, 5'd4, 1, 0, 1, 1, 0, 1);
        check("busy_ignored", bus.Mem_Data, 32'hDEAD_BEEF);
        idle(1);

        // reset on the first busy cycle aborts the store
        issue(32'h0000_000C, 32'hA5A5_0C0C, 5'd0, 0, 1, 0, 0, 0, 1);
        issue(32'h0000_000C, 32'h0BAD_F00D, 5'd0, 0, 1, 0, 0, 0, 0);
        do_reset(1);
        check("abort_stall", {31'b0, bus.stall}, 32'd0);
        issue(32'h0000_000C, 32'h0, 5'd6, 1, 0, 1, 1, 0, 1);
        check("abort_Mem_Data", bus.Mem_Data, 32'hA5A5_0C0C);

        // reset while idle with a store on the inputs leaves memory alone
        do_reset(2);
        issue(32'h0000_0008, 32'h0, 5'd8, 1, 0, 1, 1, 0, 1);
        check("rst_mem_kept", bus.Wb_Data, 32'hDEAD_BEEF);

        // both mem_R and mem_W behave as a store
        issue(32'h0000_0020, 32'h55AA_55AA, 5'd10, 1, 1, 1, 0, 0, 1);
        check("rw_Mem_Data", bus.Mem_Data, 32'h0);
        issue(32'hFFFF_FC20, 32'h0, 5'd11, 1, 0, 0, 1, 0, 1);
        check("rw_wrap_Wb_Data", bus.Wb_Data, 32'hFFFF_FC20);
        check("rw_load_Mem_Data", bus.Mem_Data, 32'h55AA_55AA);

        // ALU op with WB=1 selects the (zero) memory data
        issue(32'hCAFE_0001, 32'h0, 5'd12, 0, 0, 1, 1, 0, 1);
        check("alu_wb1_Wb_Data", bus.Wb_Data, 32'h0);
        idle(3);

        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
